// File: rtl/local_network_interface_pkg.sv
// rtl/local_network_interface_pkg.sv - shared mesh configuration and packet format
package local_network_interface_pkg;

    // Mesh dimensions (columns N, rows M)
    localparam int N = 4;
    localparam int M = 4;

    localparam int X_W      = (N > 1) ? $clog2(N) : 1;
    localparam int Y_W      = (M > 1) ? $clog2(M) : 1;
    localparam int PKT_TS_W = 16;
    localparam int DATA_W   = 16;

    typedef struct packed {
        logic [X_W-1:0]      x_source;
        logic [Y_W-1:0]      y_source;
        logic [X_W-1:0]      x_dest;
        logic [Y_W-1:0]      y_dest;
        logic                measure;
        logic [PKT_TS_W-1:0] timestamp;
        logic [DATA_W-1:0]   data;
    } packet_t;

endpackage

// File: rtl/local_network_interface_inject_fifo.sv
// rtl/local_network_interface_inject_fifo.sv - synchronous packet FIFO for the inject path
module ni_inject_fifo
    import local_network_interface_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  packet_t push_data,
    input  logic    pop,
    output packet_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    packet_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/local_network_interface.sv
// rtl/local_network_interface.sv - core-to-router network interface with latency statistics
module local_network_interface
    import local_network_interface_pkg::*;
#(
    parameter int X_LOC     = 0,
    parameter int Y_LOC     = 0,
    parameter int INJ_DEPTH = 4,
    parameter int TS_W      = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  packet_t          i_core_data,
    input  logic             i_core_val,
    output logic             o_core_rdy,
    output packet_t          o_core_data,
    output logic             o_core_val,
    input  logic             i_core_rdy,
    output packet_t          o_net_data,
    output logic             o_net_data_val,
    input  logic             i_net_en,
    input  packet_t          i_net_data,
    input  logic             i_net_data_val,
    output logic             o_net_en,
    output logic [CNT_W-1:0] o_tx_count,
    output logic [CNT_W-1:0] o_rx_count,
    output logic [CNT_W-1:0] o_lat_sum
);

    localparam int              SW      = ((CNT_W > TS_W) ? CNT_W : TS_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]  cyc;
    packet_t          push_pkt;
    packet_t          fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             core_push;
    logic             net_pop;

    packet_t          core_data_q;
    logic             core_val_q;
    logic             eject_load;

    logic [CNT_W-1:0] tx_q;
    logic [CNT_W-1:0] rx_q;
    logic [CNT_W-1:0] lat_q;
    logic [TS_W-1:0]  latency;
    logic [SW-1:0]    lat_sum_wide;

    // Free-running timestamp source
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc <= '0;
        end else begin
            cyc <= cyc + 1'b1;
        end
    end

    // Stamp node coordinates and injection time onto the core packet
    always_comb begin
        push_pkt           = i_core_data;
        push_pkt.x_source  = X_W'(X_LOC);
        push_pkt.y_source  = Y_W'(Y_LOC);
        push_pkt.timestamp = PKT_TS_W'(cyc);
    end

    assign o_core_rdy     = !reset && !fifo_full;
    assign core_push      = i_core_val && o_core_rdy;
    assign o_net_data_val = !reset && !fifo_empty && i_net_en;
    assign net_pop        = o_net_data_val;
    assign o_net_data     = (reset || fifo_empty) ? '0 : fifo_head;

    ni_inject_fifo #(
        .DEPTH (INJ_DEPTH)
    ) u_inject_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (core_push),
        .push_data (push_pkt),
        .pop       (net_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // One-entry eject register: accepting and reloading in one cycle keeps valid high
    assign o_net_en    = !core_val_q || i_core_rdy;
    assign eject_load  = i_net_data_val && o_net_en;
    assign o_core_val  = core_val_q;
    assign o_core_data = core_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            core_val_q  <= 1'b0;
            core_data_q <= '0;
        end else if (eject_load) begin
            core_val_q  <= 1'b1;
            core_data_q <= i_net_data;
        end else if (i_core_rdy) begin
            core_val_q  <= 1'b0;
        end
    end

    // Latency uses modular subtraction so a counter wrap between stamp and eject is harmless
    assign latency      = cyc - TS_W'(i_net_data.timestamp);
    assign lat_sum_wide = SW'(lat_q) + SW'(latency);

    // Saturating traffic statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q  <= '0;
            rx_q  <= '0;
            lat_q <= '0;
        end else begin
            if (net_pop && tx_q != CNT_MAX) begin
                tx_q <= tx_q + 1'b1;
            end
            if (eject_load && i_net_data.measure) begin
                if (rx_q != CNT_MAX) begin
                    rx_q <= rx_q + 1'b1;
                end
                if (lat_sum_wide > SW'(CNT_MAX)) begin
                    lat_q <= CNT_MAX;
                end else begin
                    lat_q <= lat_sum_wide[CNT_W-1:0];
                end
            end
        end
    end

    assign o_tx_count = tx_q;
    assign o_rx_count = rx_q;
    assign o_lat_sum  = lat_q;

    // The router must not present data while the eject register is blocked
    property p_no_data_when_blocked;
        @(posedge clk) disable iff (reset) i_net_data_val |-> o_net_en;
    endproperty
    a_no_data_when_blocked: assert property (p_no_data_when_blocked);

endmodule

// File: tb/tb_local_network_interface.sv
// tb/tb_local_network_interface.sv - scoreboard bench for local_network_interface
module tb_local_network_interface;
    import local_network_interface_pkg::*;

    localparam int X_LOC     = 2;
    localparam int Y_LOC     = 1;
    localparam int INJ_DEPTH = 4;
    localparam int TS_W      = 16;
    localparam int CNT_W     = 8;
    localparam int CMAX      = 255;

    logic             clk = 1'b0;
    logic             reset;
    packet_t          i_core_data;
    logic             i_core_val;
    logic             o_core_rdy;
    packet_t          o_core_data;
    logic             o_core_val;
    logic             i_core_rdy;
    packet_t          o_net_data;
    logic             o_net_data_val;
    logic             i_net_en;
    packet_t          i_net_data;
    logic             i_net_data_val;
    logic             o_net_en;
    logic [CNT_W-1:0] o_tx_count;
    logic [CNT_W-1:0] o_rx_count;
    logic [CNT_W-1:0] o_lat_sum;

    local_network_interface #(
        .X_LOC(X_LOC), .Y_LOC(Y_LOC), .INJ_DEPTH(INJ_DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .i_core_data(i_core_data), .i_core_val(i_core_val), .o_core_rdy(o_core_rdy),
        .o_core_data(o_core_data), .o_core_val(o_core_val), .i_core_rdy(i_core_rdy),
        .o_net_data(o_net_data), .o_net_data_val(o_net_data_val), .i_net_en(i_net_en),
        .i_net_data(i_net_data), .i_net_data_val(i_net_data_val), .o_net_en(o_net_en),
        .o_tx_count(o_tx_count), .o_rx_count(o_rx_count), .o_lat_sum(o_lat_sum)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: packet queues and plain integer statistics
    packet_t fifo_q[$];
    packet_t net_exp[$];
    packet_t core_exp[$];
    bit      hold_v;
    packet_t hold_p;
    int      cyc;
    int      tx, rx, lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic packet_t rand_pkt();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[$bits(packet_t)-1:0];
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a packet
    always @(negedge clk) begin
        if (!reset) begin
            if (o_net_data_val) begin
                if (net_exp.size() == 0) begin
                    check("net_unexpected", 64'(o_net_data_val), 64'(0));
                end else begin
                    check("net_data", 64'(o_net_data), 64'(net_exp.pop_front()));
                end
            end
            if (o_core_val && i_core_rdy) begin
                if (core_exp.size() == 0) begin
                    check("core_unexpected", 64'(o_core_val), 64'(0));
                end else begin
                    check("core_data", 64'(o_core_data), 64'(core_exp.pop_front()));
                end
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1; i_core_val = 1'b1; i_core_data = rand_pkt();
        i_net_en = 1'b1; i_core_rdy = 1'b0; i_net_data_val = 1'b0; i_net_data = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            check("rst_core_rdy", 64'(o_core_rdy), 64'(0));
            check("rst_net_val", 64'(o_net_data_val), 64'(0));
            check("rst_core_val", 64'(o_core_val), 64'(0));
            check("rst_counts", {o_tx_count, o_rx_count, o_lat_sum}, 64'(0));
        end
        fifo_q.delete(); net_exp.delete(); core_exp.delete();
        hold_v = 1'b0; hold_p = '0; cyc = 0; tx = 0; rx = 0; lat = 0;
    endtask

    task automatic cycle(input bit cv, input packet_t cp, input bit ne, input bit cr,
                         input bit nv, input packet_t np);
        bit      en_exp;
        bit      was_full;
        packet_t s;
        @(posedge clk); #1;
        reset  = 1'b0;
        en_exp = !hold_v || cr;
        if (!en_exp) nv = 1'b0;
        i_core_val = cv; i_core_data = cp; i_net_en = ne;
        i_core_rdy = cr; i_net_data_val = nv; i_net_data = np;
        #1;
        was_full = (fifo_q.size() >= INJ_DEPTH);
        check("core_rdy", 64'(o_core_rdy), 64'(!was_full));
        check("net_en", 64'(o_net_en), 64'(en_exp));
        check("net_val", 64'(o_net_data_val), 64'(fifo_q.size() > 0 && ne));
        check("core_val", 64'(o_core_val), 64'(hold_v));
        check("tx_count", 64'(o_tx_count), 64'(tx));
        check("rx_count", 64'(o_rx_count), 64'(rx));
        check("lat_sum", 64'(o_lat_sum), 64'(lat));
        if (fifo_q.size() > 0 && ne) begin
            net_exp.push_back(fifo_q.pop_front());
            tx = sat(tx + 1);
        end
        if (cv && !was_full) begin
            s = cp;
            s.x_source = X_W'(X_LOC);
            s.y_source = Y_W'(Y_LOC);
            s.timestamp = PKT_TS_W'(cyc);
            fifo_q.push_back(s);
        end
        if (hold_v && cr) core_exp.push_back(hold_p);
        if (nv) begin
            hold_p = np; hold_v = 1'b1;
            if (np.measure) begin
                rx  = sat(rx + 1);
                lat = sat(lat + ((cyc - int'(np.timestamp)) & 32'hFFFF));
            end
        end else if (cr) begin
            hold_v = 1'b0;
        end
        cyc = (cyc + 1) & 32'hFFFF;
    endtask

    task automatic idle(input int n, input bit ne, input bit cr);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, ne, cr, 1'b0, '0);
    endtask

    task automatic run_random(input int n);
        packet_t np;
        for (int i = 0; i < n; i++) begin
            np = rand_pkt();
            np.timestamp = PKT_TS_W'(cyc - int'($urandom_range(0, 40)));
            cycle($urandom_range(0, 1) == 1, rand_pkt(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, np);
        end
    endtask

    initial begin
        packet_t p;
        packet_t a;
        packet_t b;
        do_reset(3);

        // Single packet pushed at counter 5 toward (2,1)
        idle(5, 1'b1, 1'b1);
        p = rand_pkt(); p.x_dest = 2'd2; p.y_dest = 2'd1;
        cycle(1'b1, p, 1'b1, 1'b1, 1'b0, '0);
        idle(3, 1'b1, 1'b1);

        // Fill with router stalled, then drain in order
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_pkt(), 1'b0, 1'b1, 1'b0, '0);
        idle(6, 1'b1, 1'b1);

        // Simultaneous push and pop at occupancy 2
        for (int i = 0; i < 2; i++) cycle(1'b1, rand_pkt(), 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_pkt(), 1'b1, 1'b1, 1'b0, '0);
        idle(4, 1'b1, 1'b1);

        // Eject latency across timestamp wrap, then back-to-back with core stalled
        do_reset(2);
        idle(3, 1'b1, 1'b0);
        a = rand_pkt(); a.measure = 1'b1; a.timestamp = 16'hFFFE;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, a);
        b = rand_pkt(); b.measure = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, b);
        check("wrap_lat_sum", 64'(o_lat_sum), 64'(5));
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, b);
        idle(2, 1'b1, 1'b1);

        // Random traffic, including counter saturation
        do_reset(1);
        run_random(300);
        do_reset(2);
        run_random(2500);
        idle(8, 1'b1, 1'b1);
        @(negedge clk);
        check("drain_fifo", 64'(fifo_q.size()), 64'(0));
        check("drain_net_exp", 64'(net_exp.size()), 64'(0));
        check("drain_core_exp", 64'(core_exp.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
